// File: rtl/uart_frame_gen.sv
// -----------------------------------------------------------------------------
// uart_frame_gen
//
// UART frame generator fed by a small FIFO. Bytes pushed into the FIFO are
// serialised onto 'tx' as: start bit (0), DATA_BITS data bits LSB first, an
// optional parity bit, STOP_BITS stop bits (1) and GAP_BITS extra idle bit
// periods. Every bit lasts exactly CLK_DIV sysclk cycles. Queued bytes are sent
// back to back with no idle cycle between frames.
//
// Parameters:
//   CLK_DIV    sysclk cycles per bit period (>= 2)
//   DATA_BITS  data bits per frame (5..9)
//   PARITY     0 = none, 1 = odd, 2 = even
//   STOP_BITS  stop bits per frame (1 or 2)
//   GAP_BITS   extra idle bit periods after the stop bits (0..15)
//   FIFO_DEPTH FIFO entries (power of two, >= 2)
//
// Ports:
//   sysclk      in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   wr_en       in   push wr_data into the FIFO
//   wr_data     in   DATA_BITS word to send
//   hold        in   inhibit the start of new frames
//   full        out  FIFO holds FIFO_DEPTH entries (registered)
//   empty       out  FIFO holds no entries (registered)
//   overflow    out  one-cycle pulse after a write was dropped because full
//   busy        out  a frame is in progress (registered)
//   frame_done  out  one-cycle pulse during the last cycle of each frame
//   tx          out  serial line, idle high (registered)
//   fsm_state   out  current frame state, for observation only
//
// Write handshake: wr_en is a valid strobe and !full is the ready. A word is
// taken on a rising edge iff wr_en=1 and the registered full=0 at that edge.
// A wr_en seen while full is dropped and flagged by overflow on the following
// cycle. A push and a pop on the same edge both happen.
// -----------------------------------------------------------------------------
module uart_frame_gen #(
   parameter int CLK_DIV    = 10416,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int GAP_BITS   = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 sysclk,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic [DATA_BITS-1:0] wr_data,
   input  logic                 hold,
   output logic                 full,
   output logic                 empty,
   output logic                 overflow,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 tx,
   output logic [2:0]           fsm_state
);

   // --------------------------------------------------------------------------
   // Local sizes and constants
   // --------------------------------------------------------------------------
   localparam int CW   = $clog2(CLK_DIV);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CNTW = AW + 1;

   localparam logic [CW-1:0]   BIT_LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0]   BIT_PRE   = CW'(CLK_DIV - 2);
   localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);
   localparam logic [3:0]      GAP_LAST  = 4'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
   localparam logic [CNTW-1:0] CNT_FULL  = CNTW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_GAP    = 3'd5
   } state_t;

   // --------------------------------------------------------------------------
   // Declarations
   // --------------------------------------------------------------------------
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [CNTW-1:0]      count;
   logic [CNTW-1:0]      count_nxt;
   logic                 push;
   logic                 pop;
   logic [DATA_BITS-1:0] head;

   state_t               state;
   logic [CW-1:0]        bit_cnt;
   logic [3:0]           bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;
   logic                 par_calc;
   logic                 start_ok;
   logic                 bit_last;
   logic                 frame_last_bit;
   logic                 frame_end;

   assign fsm_state = state;

   // --------------------------------------------------------------------------
   // FIFO
   // --------------------------------------------------------------------------
   assign head = mem[rd_ptr];
   assign push = wr_en && !full;

   // A new frame may start only with data queued and hold low.
   assign start_ok = !empty && !hold;

   // The head is popped exactly when a frame is launched, either from IDLE or
   // straight out of the last cycle of the previous frame.
   assign pop = start_ok && ((state == S_IDLE) || frame_end);

   always_comb begin
      count_nxt = count;
      if (push && !pop) begin
         count_nxt = count + 1'b1;
      end else if (!push && pop) begin
         count_nxt = count - 1'b1;
      end
   end

   always_ff @(posedge sysclk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         overflow <= wr_en && full;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count_nxt;
         full  <= (count_nxt == CNT_FULL);
         empty <= (count_nxt == '0);
      end
   end

   // --------------------------------------------------------------------------
   // Frame timing helpers
   // --------------------------------------------------------------------------
   // Parity over the word being launched; odd parity inverts the XOR.
   assign par_calc = (^head) ^ (PARITY == 1);

   assign bit_last = (bit_cnt == BIT_LAST);

   // True while the final bit period of the frame is on the line: the last
   // stop bit when there is no gap, otherwise the last gap bit.
   always_comb begin
      frame_last_bit = 1'b0;
      if (GAP_BITS == 0) begin
         frame_last_bit = (state == S_STOP) && (bit_idx == STOP_LAST);
      end else begin
         frame_last_bit = (state == S_GAP) && (bit_idx == GAP_LAST);
      end
   end

   assign frame_end = (state != S_IDLE) && bit_last && frame_last_bit;

   // --------------------------------------------------------------------------
   // Frame FSM. tx, busy and frame_done are registered alongside the state so
   // the line changes on the same edge as the state does.
   // --------------------------------------------------------------------------
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         tx         <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         bit_cnt    <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         par_bit    <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if ((state == S_IDLE) || frame_end) begin
            // Frame-start decision point: launch the head word or go idle.
            bit_cnt <= '0;
            bit_idx <= '0;
            if (start_ok) begin
               state   <= S_START;
               tx      <= 1'b0;
               busy    <= 1'b1;
               shreg   <= head;
               par_bit <= par_calc;
            end else begin
               state <= S_IDLE;
               tx    <= 1'b1;
               busy  <= 1'b0;
            end
         end else if (!bit_last) begin
            bit_cnt <= bit_cnt + 1'b1;
            // Raise frame_done for the one cycle that closes the frame.
            if (frame_last_bit && (bit_cnt == BIT_PRE)) begin
               frame_done <= 1'b1;
            end
         end else begin
            bit_cnt <= '0;
            case (state)
               S_START: begin
                  state   <= S_DATA;
                  bit_idx <= '0;
                  tx      <= shreg[0];
               end
               S_DATA: begin
                  if (bit_idx == DATA_LAST) begin
                     bit_idx <= '0;
                     if (PARITY != 0) begin
                        state <= S_PARITY;
                        tx    <= par_bit;
                     end else begin
                        state <= S_STOP;
                        tx    <= 1'b1;
                     end
                  end else begin
                     bit_idx <= bit_idx + 4'd1;
                     shreg   <= shreg >> 1;
                     tx      <= shreg[1];
                  end
               end
               S_PARITY: begin
                  state   <= S_STOP;
                  bit_idx <= '0;
                  tx      <= 1'b1;
               end
               S_STOP: begin
                  // The last stop bit with no gap is handled as frame_end.
                  if (bit_idx == STOP_LAST) begin
                     state   <= S_GAP;
                     bit_idx <= '0;
                  end else begin
                     bit_idx <= bit_idx + 4'd1;
                  end
                  tx <= 1'b1;
               end
               S_GAP: begin
                  // The last gap bit is handled as frame_end.
                  bit_idx <= bit_idx + 4'd1;
                  tx      <= 1'b1;
               end
               default: begin
                  state <= S_IDLE;
                  tx    <= 1'b1;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_gen.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_gen
//
// Three generators with different framing share one clock and reset:
//   a: 8N1, no gap        b: 7 data, odd parity, 2 stop, 1 gap
//   c: 8 data, even parity, 1 stop
// All use CLK_DIV=4 and FIFO_DEPTH=4. Expected line waveforms are built from
// the framing rules as a list of bit values per frame.
// -----------------------------------------------------------------------------
module tb_uart_frame_gen;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic sysclk;
   logic reset;

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   // ---------------------------------------------------------------------------
   // DUT signals (index 0 = a, 1 = b, 2 = c)
   // ---------------------------------------------------------------------------
   logic [2:0] wr_en;
   logic [2:0] hold;
   logic [7:0] wr_data_a;
   logic [6:0] wr_data_b;
   logic [7:0] wr_data_c;
   wire  [2:0] full;
   wire  [2:0] empty;
   wire  [2:0] overflow;
   wire  [2:0] busy;
   wire  [2:0] frame_done;
   wire  [2:0] tx;
   wire  [2:0] st_a;
   wire  [2:0] st_b;
   wire  [2:0] st_c;

   uart_frame_gen #(
      .CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .GAP_BITS(0), .FIFO_DEPTH(4)
   ) dut_a (
      .sysclk(sysclk), .reset(reset), .wr_en(wr_en[0]), .wr_data(wr_data_a), .hold(hold[0]),
      .full(full[0]), .empty(empty[0]), .overflow(overflow[0]), .busy(busy[0]),
      .frame_done(frame_done[0]), .tx(tx[0]), .fsm_state(st_a)
   );

   uart_frame_gen #(
      .CLK_DIV(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .GAP_BITS(1), .FIFO_DEPTH(4)
   ) dut_b (
      .sysclk(sysclk), .reset(reset), .wr_en(wr_en[1]), .wr_data(wr_data_b), .hold(hold[1]),
      .full(full[1]), .empty(empty[1]), .overflow(overflow[1]), .busy(busy[1]),
      .frame_done(frame_done[1]), .tx(tx[1]), .fsm_state(st_b)
   );

   uart_frame_gen #(
      .CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .GAP_BITS(0), .FIFO_DEPTH(4)
   ) dut_c (
      .sysclk(sysclk), .reset(reset), .wr_en(wr_en[2]), .wr_data(wr_data_c), .hold(hold[2]),
      .full(full[2]), .empty(empty[2]), .overflow(overflow[2]), .busy(busy[2]),
      .frame_done(frame_done[2]), .tx(tx[2]), .fsm_state(st_c)
   );

   // Framing of each instance, as seen by the reference model.
   int cfg_div  [3] = '{4, 4, 4};
   int cfg_bits [3] = '{8, 7, 8};
   int cfg_par  [3] = '{0, 1, 2};
   int cfg_stop [3] = '{1, 2, 1};
   int cfg_gap  [3] = '{0, 1, 0};

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   logic [7:0] exp_q[$];      // words accepted and not yet seen on the line
   logic [7:0] wbuf [8];      // words for the next write burst
   int         compared   = 0;
   int         mismatched = 0;
   int         lat;
   int         cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Driver tasks (called at a falling edge, leave at a falling edge)
   // ---------------------------------------------------------------------------
   task automatic write_burst(input int inst, input int n, input bit chk_full);
      for (int i = 0; i < n; i++) begin
         wr_en[inst] = 1'b1;
         case (inst)
            0:       wr_data_a = wbuf[i];
            1:       wr_data_b = wbuf[i][6:0];
            default: wr_data_c = wbuf[i];
         endcase
         exp_q.push_back(wbuf[i]);
         @(negedge sysclk);
         if (chk_full) chk($sformatf("full_in_burst_i%0d", inst), full[inst], 1'b0);
      end
      wr_en[inst] = 1'b0;
   endtask

   // Counts falling edges until tx is seen low; stops at max_cyc.
   task automatic wait_start(input int inst, input int max_cyc, output int l);
      l = 0;
      while (tx[inst] !== 1'b0 && l < max_cyc) begin
         @(negedge sysclk);
         l++;
      end
   endtask

   // Entered in the first cycle of a frame (start bit on the line). Checks every
   // cycle of the frame, then the cycle after it: next start bit or idle line.
   task automatic check_frame(input int inst);
      logic [7:0] d;
      logic       bits [32];
      logic       p;
      int         n;
      int         dv;
      bit         more;
      chk($sformatf("sb_has_word_i%0d", inst), exp_q.size() > 0, 1'b1);
      if (exp_q.size() == 0) return;
      d = exp_q.pop_front();
      n = 0;
      bits[n] = 1'b0; n++;
      for (int i = 0; i < cfg_bits[inst]; i++) begin
         bits[n] = d[i]; n++;
      end
      if (cfg_par[inst] != 0) begin
         p = 1'b0;
         for (int i = 0; i < cfg_bits[inst]; i++) p = p ^ d[i];
         if (cfg_par[inst] == 1) p = ~p;
         bits[n] = p; n++;
      end
      for (int i = 0; i < cfg_stop[inst] + cfg_gap[inst]; i++) begin
         bits[n] = 1'b1; n++;
      end
      dv = cfg_div[inst];
      for (int c = 1; c <= n * dv; c++) begin
         chk($sformatf("tx_i%0d_d%02h_bit%0d_c%0d", inst, d, (c - 1) / dv, c),
             tx[inst], bits[(c - 1) / dv]);
         chk($sformatf("frame_done_i%0d_c%0d", inst, c), frame_done[inst], (c == n * dv));
         chk($sformatf("busy_i%0d_c%0d", inst, c), busy[inst], 1'b1);
         @(negedge sysclk);
      end
      more = (exp_q.size() > 0) && !hold[inst];
      if (more) begin
         chk($sformatf("next_start_i%0d", inst), tx[inst], 1'b0);
      end else begin
         chk($sformatf("idle_tx_i%0d", inst), tx[inst], 1'b1);
         chk($sformatf("idle_busy_i%0d", inst), busy[inst], 1'b0);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Watchdog
   // ---------------------------------------------------------------------------
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      wr_en     = '0;
      hold      = '0;
      wr_data_a = '0;
      wr_data_b = '0;
      wr_data_c = '0;
      reset     = 1'b0;
      repeat (3) @(negedge sysclk);

      // Reset values.
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_tx_i%0d", i), tx[i], 1'b1);
         chk($sformatf("rst_busy_i%0d", i), busy[i], 1'b0);
         chk($sformatf("rst_full_i%0d", i), full[i], 1'b0);
         chk($sformatf("rst_empty_i%0d", i), empty[i], 1'b1);
         chk($sformatf("rst_overflow_i%0d", i), overflow[i], 1'b0);
         chk($sformatf("rst_frame_done_i%0d", i), frame_done[i], 1'b0);
      end
      chk("rst_state_a", st_a, 3'd0);
      chk("rst_state_b", st_b, 3'd0);
      chk("rst_state_c", st_c, 3'd0);
      reset = 1'b1;
      @(negedge sysclk);

      // Single word 0xA5 on 8N1: start bit one edge after the write edge.
      wbuf[0] = 8'hA5;
      fork
         write_burst(0, 1, 1'b0);
         begin
            wait_start(0, 10, lat);
            chk("single_latency", lat, 2);
            check_frame(0);
         end
      join
      chk("single_empty_after", empty[0], 1'b1);

      // Back-to-back frames from consecutive writes.
      wbuf[0] = 8'h00; wbuf[1] = 8'hFF; wbuf[2] = 8'h55; wbuf[3] = 8'h0F;
      fork
         write_burst(0, 4, 1'b1);
         begin
            wait_start(0, 10, lat);
            chk("b2b_latency", lat, 2);
            repeat (4) check_frame(0);
         end
      join
      chk("b2b_empty_after", empty[0], 1'b1);

      // Overflow while held: four accepted, fifth dropped.
      hold[0] = 1'b1;
      for (int i = 0; i < 5; i++) wbuf[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 5; i++) begin
         wr_en[0]  = 1'b1;
         wr_data_a = wbuf[i];
         if (i < 4) exp_q.push_back(wbuf[i]);
         @(negedge sysclk);
         chk($sformatf("ovf_full_w%0d", i), full[0], (i >= 3));
         chk($sformatf("ovf_pulse_w%0d", i), overflow[0], (i == 4));
         chk($sformatf("ovf_tx_held_w%0d", i), tx[0], 1'b1);
      end
      wr_en[0] = 1'b0;
      @(negedge sysclk);
      chk("ovf_pulse_gone", overflow[0], 1'b0);
      chk("ovf_still_full", full[0], 1'b1);
      chk("ovf_tx_idle", tx[0], 1'b1);
      hold[0] = 1'b0;
      wait_start(0, 10, lat);
      chk("ovf_release_latency", lat, 1);
      repeat (4) check_frame(0);
      chk("ovf_empty_after", empty[0], 1'b1);
      chk("ovf_sb_drained", exp_q.size(), 0);

      // hold raised mid-frame: current frame completes, next one waits.
      wbuf[0] = 8'($urandom_range(0, 255));
      wbuf[1] = 8'($urandom_range(0, 255));
      fork
         write_burst(0, 2, 1'b0);
         begin
            wait_start(0, 10, lat);
            chk("hold_latency", lat, 2);
            fork
               check_frame(0);
               begin
                  repeat ($urandom_range(5, 30)) @(negedge sysclk);
                  hold[0] = 1'b1;
               end
            join
         end
      join
      wait_start(0, 30, lat);
      chk("hold_no_start", lat, 30);
      chk("hold_queued", empty[0], 1'b0);
      hold[0] = 1'b0;
      wait_start(0, 10, lat);
      chk("hold_release_latency", lat, 1);
      check_frame(0);

      // Parity / two stop bits / gap on instance b.
      wbuf[0] = 8'h03;
      wbuf[1] = 8'($urandom_range(0, 127));
      fork
         write_burst(1, 2, 1'b1);
         begin
            wait_start(1, 10, lat);
            chk("b_latency", lat, 2);
            repeat (2) check_frame(1);
         end
      join

      // Even parity on instance c: directed words first, then random bursts.
      for (int r = 0; r < 4; r++) begin
         if (r == 0) begin
            cnt = 2;
            wbuf[0] = 8'h07;
            wbuf[1] = 8'h03;
         end else begin
            cnt = $urandom_range(1, 4);
            for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom_range(0, 255));
         end
         fork
            write_burst(2, cnt, 1'b1);
            begin
               wait_start(2, 10, lat);
               chk($sformatf("c_latency_r%0d", r), lat, 2);
               repeat (cnt) check_frame(2);
            end
         join
         repeat ($urandom_range(0, 5)) @(negedge sysclk);
      end

      // Reset during data bit 3 of a frame with a second word queued.
      wbuf[0] = 8'($urandom_range(0, 255));
      wbuf[1] = 8'($urandom_range(0, 255));
      fork
         write_burst(0, 2, 1'b0);
         begin
            wait_start(0, 10, lat);
            chk("rstmid_latency", lat, 2);
         end
      join
      repeat (17) @(negedge sysclk);
      chk("rstmid_data_bit3", tx[0], wbuf[0][3]);
      #2 reset = 1'b0;
      #1;
      chk("rstmid_tx", tx[0], 1'b1);
      chk("rstmid_empty", empty[0], 1'b1);
      chk("rstmid_busy", busy[0], 1'b0);
      chk("rstmid_full", full[0], 1'b0);
      exp_q.delete();
      @(negedge sysclk);
      reset = 1'b1;
      wait_start(0, 60, lat);
      chk("rstmid_no_frame", lat, 60);
      chk("rstmid_still_empty", empty[0], 1'b1);
      wbuf[0] = 8'($urandom_range(0, 255));
      fork
         write_burst(0, 1, 1'b0);
         begin
            wait_start(0, 10, lat);
            chk("rstmid_new_latency", lat, 2);
            check_frame(0);
         end
      join

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/uart_frame_gen.md
Name: uart_frame_gen

Overview:
Parametrised, synthesizable UART frame generator with an input FIFO. It drives a UART line such as the CPU UART_RX input. It replaces hand-timed serial stimulus with exact, programmable framing: data width, parity, stop bits and inter-frame gap. It can be used as on-board loopback stimulus or as a bench driver.

Parameters:
CLK_DIV, 10416, sysclk cycles per bit period (≥2)
DATA_BITS, 8, data bits per frame (5..9)
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame (1 or 2)
GAP_BITS, 0, extra idle bit periods after stop bits (0..15)
FIFO_DEPTH, 4, FIFO entries (power of two, ≥2)

Ports:
sysclk  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-low reset
wr_en  in  1  push wr_data into FIFO
wr_data  in  DATA_BITS  byte to send
hold  in  1  inhibit start of new frames
full  out  1  FIFO full (count == FIFO_DEPTH)
empty  out  1  FIFO empty
overflow  out  1  one-cycle pulse: wr_en while full
busy  out  1  a frame is in progress
frame_done  out  1  one-cycle pulse at end of each frame
tx  out  1  serial line, idle high, registered

Behaviour:
- Reset (reset=0, async): tx=1, busy=0, full=0, empty=1, overflow=0, frame_done=0, FIFO flushed, FSM=IDLE, counters 0.
- Reset asserted mid-frame: line returns high immediately and the frame is abandoned.
- Write acceptance:
  - A write is accepted iff wr_en=1 and full=0, judged on the registered full.
  - A write while full is dropped and overflow=1 for the next cycle.
  - A write and a pop in the same cycle are both performed; count is unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP, GAP.
- IDLE:
  - If empty=0 and hold=0 at a rising edge: pop the head, enter START, tx=0 from that edge.
  - A write into an empty, idle block produces the tx falling edge on the clock edge after the write edge (latency 1).
- Bit timing: each bit holds tx for exactly CLK_DIV cycles, counted by a bit-timer 0..CLK_DIV-1.
- START → DATA: DATA_BITS bits, LSB first.
- DATA → PARITY if PARITY≠0, else → STOP.
  - Parity bit = XOR of data bits for even, inverted XOR for odd.
- STOP: tx=1 for STOP_BITS×CLK_DIV cycles.
- GAP: tx=1 for GAP_BITS×CLK_DIV cycles; skipped if GAP_BITS=0.
- Frame end:
  - On the last cycle of STOP (or of GAP if used), frame_done=1 for exactly that cycle.
  - If empty=0 and hold=0, go directly to START with no idle cycle. Otherwise go to IDLE.
  - Back-to-back frames are therefore exactly (1+DATA_BITS+(PARITY≠0)+STOP_BITS+GAP_BITS)×CLK_DIV cycles apart.
- hold:
  - Sampled only at frame-start decisions.
  - Raising hold mid-frame never truncates the current frame.
  - Dropping hold in IDLE with data queued starts a frame on the next edge.
- busy = 1 in every state except IDLE. tx and busy are registered outputs.
- The data shift register is loaded at pop. FIFO writes during a frame never alter the frame in flight.

Test Plan:
- Single byte, CLK_DIV=4, 8N1: reset → write 0xA5 → tx low 1 cycle after write. Bit sequence 0,1,0,1,0,0,1,0,1,1, each 4 cycles. frame_done pulses at cycle 40 of the frame; busy=0 after.
- Back-to-back, DEPTH=4: write 0x00,0xFF,0x55,0x0F on consecutive cycles → full=0 throughout (one popped immediately). Four frames with start bits exactly 40 cycles apart, no idle gap.
- Overflow: hold=1, write 5 bytes → full=1 after the 4th write; the 5th write is dropped and overflow pulses once. Release hold → exactly 4 frames, with bytes 1–4.
- Parity/stop/gap, DATA_BITS=7, PARITY=1, STOP_BITS=2, GAP_BITS=1, CLK_DIV=4: write 0x03 → parity bit 1. Frame length (1+7+1+2+1)×4=48 cycles start-to-start for two queued bytes.
- Even parity 8E1: write 0x07 → parity bit 1; write 0x03 → parity bit 0.
- Reset mid-frame: assert reset during data bit 3 → tx=1 and empty=1 asynchronously. After release, no frame is emitted until a new write.
